// File: rtl/ciq_select.sv
// Sixteen-entry compute issue queue with age-matrix oldest-first select for two ALU ports.
// Define CIQ_ALU1_EN to build the second (ALU1) select port; otherwise only ALU0 issues.
module ciq_select #(
  parameter int PRF_WIDTH = 6,
  parameter int ENTRIES   = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           disp_valid,
  input  logic [PRF_WIDTH-1:0]           disp_prd,
  input  logic [PRF_WIDTH-1:0]           disp_prs1,
  input  logic [PRF_WIDTH-1:0]           disp_prs2,
  input  logic                           disp_prs1_rdy,
  input  logic                           disp_prs2_rdy,
  output logic                           disp_ready,
  input  logic [ENTRIES-1:0]             wk_prs1_rdy,
  input  logic [ENTRIES-1:0]             wk_prs2_rdy,
  input  logic                           fu_rdy_alu0,
  input  logic                           fu_rdy_alu1,
  output logic                           grant_alu0,
  output logic                           grant_alu1,
  output logic [4:0]                     addr_alu0,
  output logic [4:0]                     addr_alu1,
  output logic [ENTRIES*PRF_WIDTH-1:0]   ciq_prd_flat,
  output logic [ENTRIES*PRF_WIDTH-1:0]   ciq_prs1_flat,
  output logic [ENTRIES*PRF_WIDTH-1:0]   ciq_prs2_flat,
  output logic [4:0]                     count
);
  localparam int IW = $clog2(ENTRIES);

  typedef struct packed {
    logic          found;
    logic [IW-1:0] idx;
  } sel_t;

  logic [ENTRIES-1:0]                valid, r1, r2;
  logic [ENTRIES-1:0][ENTRIES-1:0]   older;   // older[i][j]: entry i is older than entry j
  logic [PRF_WIDTH-1:0]              prd_q  [ENTRIES];
  logic [PRF_WIDTH-1:0]              prs1_q [ENTRIES];
  logic [PRF_WIDTH-1:0]              prs2_q [ENTRIES];

  logic [ENTRIES-1:0] req, mask0, mask1, issue_mask, alloc_mask;
  logic [IW-1:0]      alloc_idx;
  logic               alloc_found, accept;
  logic [4:0]         n_grant;
  sel_t               sel0, sel1;

  // Oldest requester: an entry wins when no other requesting entry is older than it.
  function automatic sel_t pick(input logic [ENTRIES-1:0] r,
                                input logic [ENTRIES-1:0][ENTRIES-1:0] age);
    sel_t s;
    logic blk;
    s = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      blk = 1'b0;
      for (int j = 0; j < ENTRIES; j++) blk = blk | (r[j] & age[j][i]);
      if (r[i] && !blk) begin
        s.found = 1'b1;
        s.idx   = IW'(i);
      end
    end
    return s;
  endfunction

  assign req        = valid & r1 & r2;
  assign disp_ready = (count != 5'(ENTRIES));
  assign accept     = disp_valid & disp_ready;

  // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    alloc_found = 1'b0;
    alloc_idx   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!valid[i] && !alloc_found) begin
        alloc_found = 1'b1;
        alloc_idx   = IW'(i);
      end
    end
  end

  always_comb begin
    sel0       = pick(req, older);
    mask0      = sel0.found ? (ENTRIES'(1) << sel0.idx) : '0;
    grant_alu0 = sel0.found & fu_rdy_alu0;
    addr_alu0  = grant_alu0 ? 5'(sel0.idx) : 5'd0;
`ifdef CIQ_ALU1_EN
    // ALU1 excludes ALU0's pick even when ALU0 is stalled, so the two never collide.
    sel1       = pick(req & ~mask0, older);
    grant_alu1 = sel1.found & fu_rdy_alu1;
    addr_alu1  = grant_alu1 ? 5'(sel1.idx) : 5'd0;
`else
    sel1       = '0;
    grant_alu1 = 1'b0;
    addr_alu1  = 5'd0;
`endif
    mask1      = sel1.found ? (ENTRIES'(1) << sel1.idx) : '0;
    issue_mask = (grant_alu0 ? mask0 : '0) | (grant_alu1 ? mask1 : '0);
    alloc_mask = (accept && alloc_found) ? (ENTRIES'(1) << alloc_idx) : '0;
    n_grant    = 5'(grant_alu0) + 5'(grant_alu1);
  end

`ifndef CIQ_ALU1_EN
  logic unused_fu_rdy_alu1;
  assign unused_fu_rdy_alu1 = fu_rdy_alu1;
`endif

  always_comb begin
    ciq_prd_flat  = '0;
    ciq_prs1_flat = '0;
    ciq_prs2_flat = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      ciq_prd_flat[i*PRF_WIDTH +: PRF_WIDTH]  = prd_q[i];
      ciq_prs1_flat[i*PRF_WIDTH +: PRF_WIDTH] = prs1_q[i];
      ciq_prs2_flat[i*PRF_WIDTH +: PRF_WIDTH] = prs2_q[i];
    end
  end

  // NOTE: state uses non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      r1    <= '0;
      r2    <= '0;
      older <= '0;
      count <= '0;
      // NOTE: tag storage is reset on purpose; the flat tag outputs must read zero after reset.
      for (int i = 0; i < ENTRIES; i++) begin
        prd_q[i]  <= '0;
        prs1_q[i] <= '0;
        prs2_q[i] <= '0;
      end
    end else if (flush) begin
      valid <= '0;
      count <= '0;
    end else begin
      valid <= (valid & ~issue_mask) | alloc_mask;
      // Wake-up only touches valid entries, so the slot being allocated takes dispatch values.
      r1    <= ((r1 | (wk_prs1_rdy & valid)) & ~alloc_mask) | (alloc_mask & {ENTRIES{disp_prs1_rdy}});
      r2    <= ((r2 | (wk_prs2_rdy & valid)) & ~alloc_mask) | (alloc_mask & {ENTRIES{disp_prs2_rdy}});
      count <= count + 5'(accept) - n_grant;
      if (accept) begin
        prd_q[alloc_idx]  <= disp_prd;
        prs1_q[alloc_idx] <= disp_prs1;
        prs2_q[alloc_idx] <= disp_prs2;
        for (int j = 0; j < ENTRIES; j++) older[j][alloc_idx] <= valid[j];
        older[alloc_idx] <= '0;
      end
    end
  end
endmodule

// File: doc/ciq_select.md
# ciq_select

Sixteen-entry compute issue queue with integrated oldest-first select for the two ALU ports. Accepts one dispatched micro-op per cycle and holds its physical destination and source tags. Tracks per-source ready bits, setting them from the per-entry wake-up match vectors. Each cycle it picks up to two ready entries by age and drives the grant/address pairs consumed by the wake-up tag broadcast and the ALU issue path.

## Interface
- PRF_WIDTH, 6, physical register tag width
- ENTRIES, 16, queue depth (fixed; addresses are 5 bits, bit 4 always 0)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all entries (branch mispredict/exception)
- disp_valid  in  1  dispatch request
- disp_prd / disp_prs1 / disp_prs2  in  PRF_WIDTH each  tags of dispatched uop
- disp_prs1_rdy / disp_prs2_rdy  in  1 each  source already available at dispatch (busy-table lookup incl. same-cycle bypass)
- disp_ready  out  1  a free entry exists; dispatch accepted when disp_valid & disp_ready
- wk_prs1_rdy / wk_prs2_rdy  in  16 each  per-entry tag-match vectors from wake-up logic
- fu_rdy_alu0 / fu_rdy_alu1  in  1 each  ALU can accept an issue this cycle
- grant_alu0 / grant_alu1  out  1 each  entry issued to that ALU this cycle
- addr_alu0 / addr_alu1  out  5 each  issuing entry index; 0 when grant low
- ciq_prd_flat / ciq_prs1_flat / ciq_prs2_flat  out  16*PRF_WIDTH each  entry tags, entry i at [i*PRF_WIDTH +: PRF_WIDTH]
- count  out  5  number of valid entries (0..16)

## Operation
- Entry state: valid, prd, prs1, prs2, r1, r2. Age matrix older[i][j] (1 = i older than j).
- Allocation: accepted uop writes the lowest-index invalid entry k; sets valid, tags, r1=disp_prs1_rdy, r2=disp_prs2_rdy. Age update: older[j][k]=1 for every currently valid j, older[k][j]=0 for all j.
- Wake-up: for each valid entry i, wk_prs1_rdy[i] sets r1[i], wk_prs2_rdy[i] sets r2[i]. Ready bits are sticky until the entry is freed. Wake-up bits for the entry being allocated this cycle are ignored; dispatch supplies same-cycle bypass.
- Request: req[i] = valid[i] & r1[i] & r2[i].
- Select ALU0: the entry with req set and no requesting entry older than it. grant_alu0 = found & fu_rdy_alu0.
- Select ALU1: same rule over req with ALU0's pick masked, independent of fu_rdy_alu0. grant_alu1 = found & fu_rdy_alu1. The two grants never name the same entry.
- Issue: a granted entry's valid clears at the next edge. Tags are retained until overwritten.
- disp_ready = (count != 16), computed from current state. Entries freed this cycle are not visible to dispatch until next cycle.
- count(next) = count + accepted dispatch − number of grants.
- flush: at the edge, all valid clear and count=0. Dispatch and wake-up in the same cycle are discarded. Grants in a flush cycle are still driven combinationally; downstream squashes them.

## Timing
- Reset values: all valid 0, r1/r2 0, age matrix 0, tags 0, count 0, disp_ready 1, grants 0, addrs 0, flat tag outputs 0.
- Grants and addresses are combinational from registered state and fu_rdy_*; zero-cycle select.
- Dispatch-to-earliest-grant: 1 cycle when both sources are ready at dispatch.
- Wake-up-to-earliest-grant: 1 cycle, since the ready bit is registered at the edge.
- A simultaneous grant and dispatch into a different entry are both honoured. A freed slot is reused no earlier than the following cycle.
- rst dominates flush and dispatch; reset mid-operation discards every entry within one edge.

## Configuration
- CIQ_ALU1_EN defined: dual-port select as above.
- CIQ_ALU1_EN undefined: ALU1 select logic removed; grant_alu1=0 and addr_alu1=0 constant, fu_rdy_alu1 ignored, count decrements by at most 1 per cycle.

## Test plan
- Reset, then idle: count=0, disp_ready=1, both grants 0, addrs 0.
- Dispatch prd=5, both sources ready, into empty queue: next cycle grant_alu0=1, addr_alu0=0; following cycle count=0.
- Dispatch A (entry 0, r1=0) then B (entry 1, ready), then assert wk_prs1_rdy[0]: B issues first on ALU0 (addr 1); cycle after the wake-up, A issues with addr 0.
- Fill 16 entries, all ready, fu_rdy both 1: disp_ready=0 while full; grants follow dispatch order pairwise (0,1), then (2,3), …; with CIQ_ALU1_EN undefined, one per cycle over 16 cycles.
- Free entry 3 while entries 4..6 are valid, re-dispatch into 3: new uop is youngest and issues after 4,5,6.
- flush with disp_valid=1 and 10 valid entries: next cycle count=0, no grants, flat tags unchanged.
